// File: rtl/onn_pkg.sv
// Shared types and constants for the oscillatory neuron bank and its run sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package onn_pkg;

  // Bank geometry: 3x5 neurons, 4 phase bits each.
  localparam int N_NEURON    = 15;
  localparam int PHASE_W     = 4;
  localparam int PHASE_VEC_W = N_NEURON * PHASE_W;

  // Flat phase vector; neuron i occupies bits [PHASE_W*i +: PHASE_W].
  typedef logic [PHASE_VEC_W-1:0] phase_vec_t;

  // Run sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } onn_state_e;

  // Host-visible run status, registered as one word.
  typedef struct packed {
    logic busy;
    logic done;
    logic converged;
    logic timeout;
  } run_status_t;

endpackage

// File: rtl/onn_run_ctrl_if.sv
// Bundles the host request/status signals and the neuron-bank control signals.
// Latency: n/a (wiring only).
// Backpressure: none; all strobes are single-cycle and must be taken when issued.
// Ports: master = sequencer side (drives re/re_n/full_tick/drop/state_cheak/state and status),
//        slave  = host + bank side (drives start/abort/ini_phase/state_changed/phi_out).
interface onn_run_ctrl_if
  import onn_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  // Host request side
  logic                start;
  logic                abort;
  phase_vec_t          ini_phase;

  // Bank feedback
  logic [N_NEURON-1:0] state_changed;
  phase_vec_t          phi_out;

  // Bank control
  logic                re;
  logic                re_n;
  logic                full_tick;
  logic                drop;
  logic                state_cheak;
  phase_vec_t          state;

  // Host status
  logic                busy;
  logic                done;
  logic                converged;
  logic                timeout;
  phase_vec_t          result_phase;
  logic [CNT_W-1:0]    period_count;

  modport master (
    input  start, abort, ini_phase, state_changed, phi_out,
    output re, re_n, full_tick, drop, state_cheak, state,
           busy, done, converged, timeout, result_phase, period_count
  );

  modport slave (
    output start, abort, ini_phase, state_changed, phi_out,
    input  re, re_n, full_tick, drop, state_cheak, state,
           busy, done, converged, timeout, result_phase, period_count
  );

endinterface

// File: rtl/onn_period_timer.sv
// Oscillation period timer: tick counter, full_tick strobe, then state_cheak and eval one cycle apart.
// Latency: full_tick on tick==TICKS_PER_PERIOD-1, state_cheak +1 cycle, eval +2 cycles.
// Backpressure: none; dropping en clears the counter and all strobes on the next edge.
// Ports: sclk/rst_n clock and async reset; en = run enable;
//        full_tick/state_cheak = bank strobes; eval = internal evaluation strobe.
module onn_period_timer #(
  parameter int TICKS_PER_PERIOD = 16
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic en,
  output logic full_tick,
  output logic state_cheak,
  output logic eval
);

  localparam int                TICK_W    = $clog2(TICKS_PER_PERIOD);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_PERIOD - 1);
  // full_tick is registered, so it is set while the counter sits one below the last tick.
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(TICKS_PER_PERIOD - 2);

  logic [TICK_W-1:0] tick_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q      <= '0;
      full_tick   <= 1'b0;
      state_cheak <= 1'b0;
      eval        <= 1'b0;
    end else if (!en) begin
      tick_q      <= '0;
      full_tick   <= 1'b0;
      state_cheak <= 1'b0;
      eval        <= 1'b0;
    end else begin
      tick_q      <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      full_tick   <= (tick_q == TICK_PRE);
      state_cheak <= full_tick;
      eval        <= state_cheak;
    end
  end

endmodule

// File: rtl/onn_run_ctrl.sv
// Run sequencer for the 15-neuron bank: load, periodic tick/check, convergence or timeout, drop.
// Latency: re for LOAD_CYCLES after start; first eval TICKS_PER_PERIOD+2 cycles after RUN entry.
// Backpressure: none; start ignored while busy, abort honoured in LOAD/RUN only.
// Ports: sclk, rst_n (async active-low); bus = onn_run_ctrl_if.master carrying host
//        request/status and bank control/feedback signals.
module onn_run_ctrl
  import onn_pkg::*;
#(
  parameter int TICKS_PER_PERIOD = 16,
  parameter int LOAD_CYCLES      = 2,
  parameter int STABLE_PERIODS   = 3,
  parameter int MAX_PERIODS      = 255,
  parameter int CNT_W            = 8
) (
  input  logic           sclk,
  input  logic           rst_n,
  onn_run_ctrl_if.master bus
);

  localparam int               LD_W       = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LD_W-1:0]  LD_LAST    = LD_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_TGT = CNT_W'(STABLE_PERIODS);
  localparam logic [CNT_W-1:0] MAX_TGT    = CNT_W'(MAX_PERIODS);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  onn_state_e       fsm_q, fsm_d;
  logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, pcnt_inc;
  logic [CNT_W-1:0] stab_q, stab_d, stab_inc;
  phase_vec_t       state_q, state_d;
  phase_vec_t       result_q, result_d;
  logic             re_q, re_d;
  logic             drop_q, drop_d;
  run_status_t      stat_q, stat_d;

  logic             timer_en;
  logic             full_tick;
  logic             state_cheak;
  logic             eval;

  // Timer runs only while staying in RUN, so leaving RUN (abort or decision)
  // clears it in the same edge and no stray strobe appears in IDLE/DONE.
  assign timer_en = (fsm_q == RUN) && (fsm_d == RUN);

  onn_period_timer #(
    .TICKS_PER_PERIOD (TICKS_PER_PERIOD)
  ) u_timer (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .en          (timer_en),
    .full_tick   (full_tick),
    .state_cheak (state_cheak),
    .eval        (eval)
  );

  // Next state and next register values.
  always_comb begin
    fsm_d    = fsm_q;
    ld_cnt_d = ld_cnt_q;
    pcnt_d   = pcnt_q;
    stab_d   = stab_q;
    state_d  = state_q;
    result_d = result_q;
    re_d     = 1'b0;
    drop_d   = 1'b0;
    stat_d   = stat_q;

    // Saturating increments; a single changed neuron resets the quiet streak.
    pcnt_inc = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + 1'b1;
    if (bus.state_changed != '0) begin
      stab_inc = '0;
    end else begin
      stab_inc = (stab_q == CNT_MAX) ? stab_q : stab_q + 1'b1;
    end

    case (fsm_q)
      IDLE, DONE: begin
        // abort is meaningless here, so start always wins.
        if (bus.start) begin
          state_d          = bus.ini_phase;
          pcnt_d           = '0;
          stab_d           = '0;
          ld_cnt_d         = '0;
          stat_d.converged = 1'b0;
          stat_d.timeout   = 1'b0;
          re_d             = 1'b1;
          fsm_d            = LOAD;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          drop_d = 1'b1;
          fsm_d  = IDLE;
        end else if (ld_cnt_q == LD_LAST) begin
          fsm_d = RUN;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          re_d     = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          drop_d = 1'b1;
          fsm_d  = IDLE;
        end else if (eval) begin
          pcnt_d = pcnt_inc;
          stab_d = stab_inc;
          // Convergence is tested first so it wins over a coincident limit hit.
          if (stab_inc >= STABLE_TGT) begin
            stat_d.converged = 1'b1;
            result_d         = bus.phi_out;
            drop_d           = 1'b1;
            fsm_d            = DONE;
          end else if (pcnt_inc >= MAX_TGT) begin
            stat_d.timeout = 1'b1;
            result_d       = bus.phi_out;
            drop_d         = 1'b1;
            fsm_d          = DONE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase

    stat_d.busy = (fsm_d == LOAD) || (fsm_d == RUN);
    stat_d.done = (fsm_d == DONE);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      ld_cnt_q <= '0;
      pcnt_q   <= '0;
      stab_q   <= '0;
      state_q  <= '0;
      result_q <= '0;
      re_q     <= 1'b0;
      drop_q   <= 1'b0;
      stat_q   <= '0;
    end else begin
      fsm_q    <= fsm_d;
      ld_cnt_q <= ld_cnt_d;
      pcnt_q   <= pcnt_d;
      stab_q   <= stab_d;
      state_q  <= state_d;
      result_q <= result_d;
      re_q     <= re_d;
      drop_q   <= drop_d;
      stat_q   <= stat_d;
    end
  end

  // re_n comes off the same flop as re, so it reads 1 throughout reset.
  assign bus.re           = re_q;
  assign bus.re_n         = ~re_q;
  assign bus.full_tick    = full_tick;
  assign bus.state_cheak  = state_cheak;
  assign bus.drop         = drop_q;
  assign bus.state        = state_q;
  assign bus.busy         = stat_q.busy;
  assign bus.done         = stat_q.done;
  assign bus.converged    = stat_q.converged;
  assign bus.timeout      = stat_q.timeout;
  assign bus.result_phase = result_q;
  assign bus.period_count = pcnt_q;

endmodule

// File: doc/onn_run_ctrl.md
Name: onn_run_ctrl

Overview:
- Run sequencer for the 15-neuron (3x5) oscillatory neuron bank.
- On start: latches the initial phase vector and drives the bank's load strobes (re/re_n). Then generates the periodic full_tick and the state_cheak strobe that follows it.
- Counts consecutive periods with no neuron phase change to declare convergence, or gives up after a period limit.
- Captures the final phase vector and stops the bank with drop. Sits between the host/pattern loader and the neuron bank.

Parameters:
- N_NEURON, 15, neuron count; sets widths of state_changed and the phase vectors.
- PHASE_W, 4, phase bits per neuron.
- TICKS_PER_PERIOD, 16, sclk cycles per oscillation period (full_tick spacing); must be >= 4.
- LOAD_CYCLES, 2, cycles re is held during the load phase (>= 1).
- STABLE_PERIODS, 3, consecutive quiet evaluations needed to declare convergence (>= 1).
- MAX_PERIODS, 255, evaluation limit before timeout; must be <= 2^CNT_W - 1.
- CNT_W, 8, width of the period and stable counters.

Ports:
- sclk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; honoured in IDLE and DONE only.
- abort  in  1  cancels an active run (LOAD or RUN).
- ini_phase  in  N_NEURON*PHASE_W  initial phases; neuron i uses bits [PHASE_W*i +: PHASE_W]; sampled on the start cycle.
- state_changed  in  N_NEURON  per-neuron change flags from the bank.
- phi_out  in  N_NEURON*PHASE_W  current phases from the bank.
- re  out  1  bank load enable.
- re_n  out  1  complement of re, driven from the same register.
- full_tick  out  1  one-cycle period strobe.
- drop  out  1  one-cycle bank stop/clear strobe.
- state_cheak  out  1  one-cycle change-check strobe.
- state  out  N_NEURON*PHASE_W  registered ini_phase copy driven to the bank.
- busy  out  1  high in LOAD and RUN.
- done  out  1  high in DONE.
- converged  out  1  valid while done; convergence reached.
- timeout  out  1  valid while done; limit reached without convergence.
- result_phase  out  N_NEURON*PHASE_W  phi_out captured at the deciding evaluation.
- period_count  out  CNT_W  evaluations completed in the current/last run.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE.
  - re=0, re_n=1.
  - full_tick, drop, state_cheak, busy, done, converged, timeout = 0.
  - state, result_phase, period_count, tick counter, stable counter = 0.
- Reset mid-run returns everything to these values immediately; no drop pulse is generated.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE/DONE + start: state<=ini_phase, clear period/stable counters, converged/timeout<=0, go to LOAD.
  - result_phase is retained until it is overwritten.
- LOAD: re=1, re_n=0 for exactly LOAD_CYCLES cycles, then go to RUN with tick=0.
- RUN: tick counts 0..TICKS_PER_PERIOD-1 and wraps.
  - full_tick=1 on the cycle tick==TICKS_PER_PERIOD-1.
  - state_cheak=1 exactly one cycle after each full_tick.
  - Evaluation happens the cycle after state_cheak, when state_changed is sampled.
  - All outputs are registered.
- Evaluation:
  - period_count++ (saturating).
  - If state_changed==0: stable++; otherwise stable<=0.
  - If stable reaches STABLE_PERIODS: converged=1.
  - Else if period_count reaches MAX_PERIODS: timeout=1.
  - On either outcome: result_phase<=phi_out, drop=1 for the next cycle, go to DONE.
  - Converged has priority when both conditions hold on the same evaluation.
- DONE: done=1 held until start.
  - start in DONE begins a new run directly.
- abort in LOAD/RUN: drop=1 one cycle, go to IDLE.
  - converged and timeout stay 0; result_phase is unchanged.
  - abort has priority over an evaluation in the same cycle.
- start while busy is ignored.
- start and abort together in IDLE/DONE: start wins, since abort has no effect outside LOAD/RUN.
- re_n == ~re at all times, including during reset.

Decomposition:
- Shared package onn_pkg:
  - FSM state enum (IDLE, LOAD, RUN, DONE).
  - Constants N_NEURON=15 and PHASE_W=4, reused by the neuron bank.
- One natural sub-module: onn_period_timer.
  - Contains the tick counter, the full_tick strobe, and the state_cheak/eval delay pipeline.
  - Enabled only in RUN.

Test Plan (defaults; start sampled at edge k):
- Timing: start at k -> re=1 during k+1..k+2; full_tick at k+18 and k+34; state_cheak at k+19; first eval at k+20.
- Convergence: state_changed=15'h0001 at evals 1-2, then 0 -> converged=1, period_count=5, drop pulse then done=1. result_phase equals phi_out at eval 5.
- Timeout: state_changed held at 15'h7FFF -> done=1, timeout=1, converged=0, period_count=255.
- Reset stable count: quiet, quiet, change, quiet x3 -> converged at eval 6, not at eval 3.
- Abort: abort in RUN at tick 7 -> drop=1 for one cycle, IDLE, done=0. A start during busy is ignored.
- Async reset: rst_n low mid-RUN -> re=0, re_n=1, busy=0, all strobes 0 before the next sclk edge.
